// File: rtl/seq_ripple_subtractor_pkg.sv
// Shared types and helpers for the sequential ripple-borrow subtractor.
// Optional signed-overflow output is enabled with SUB_OVERFLOW_EN.
package seq_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int steps(input int width, input int slice);
    return width / slice;
  endfunction

  function automatic bit slice_ok(input int width, input int slice);
    return (slice >= 1) && (slice <= width) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/seq_ripple_subtractor_if.sv
// Operand/result handshake bundle for seq_ripple_subtractor.
// The Ovf signal only exists when SUB_OVERFLOW_EN is defined.
interface seq_ripple_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
`ifdef SUB_OVERFLOW_EN
  logic             Ovf;

  modport master (output in_valid, A, B, Bin, out_ready,
                  input  in_ready, out_valid, D, Bout, Ovf);
  modport slave  (input  in_valid, A, B, Bin, out_ready,
                  output in_ready, out_valid, D, Bout, Ovf);
`else
  modport master (output in_valid, A, B, Bin, out_ready,
                  input  in_ready, out_valid, D, Bout);
  modport slave  (input  in_valid, A, B, Bin, out_ready,
                  output in_ready, out_valid, D, Bout);
`endif
endinterface

// File: rtl/seq_ripple_subtractor_slice.sv
// Combinational SLICE-bit ripple-borrow subtractor slice: d = a - b - bi.
module sub_slice #(
  parameter int SLICE = 4
) (
  output logic [SLICE-1:0] d,
  output logic             bo,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bi
);
  logic [SLICE:0] borrow;

  assign borrow[0] = bi;

  for (genvar gi = 0; gi < SLICE; gi++) begin : g_cell
    assign d[gi]        = a[gi] ^ b[gi] ^ borrow[gi];
    assign borrow[gi+1] = (~a[gi] & b[gi]) | (~a[gi] & borrow[gi]) | (b[gi] & borrow[gi]);
  end

  assign bo = borrow[SLICE];
endmodule

// File: rtl/seq_ripple_subtractor.sv
// Multi-cycle subtractor D = A - B - Bin, one SLICE-bit slice per clock, LSB first.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow flag Ovf.
module seq_ripple_subtractor
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_ripple_subtractor_if.slave bus
);
  localparam int STEPS = steps(WIDTH, SLICE);
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  if (!slice_ok(WIDTH, SLICE)) begin : g_bad_cfg
    $error("seq_ripple_subtractor: WIDTH must be a positive multiple of SLICE");
  end

  state_t           state_reg, state_next;
  logic [CW-1:0]    step_reg, step_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             borrow_reg, borrow_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic             bout_reg, bout_next;
  logic             load;

  logic [SLICE-1:0] a_slice, b_slice, d_slice;
  logic             bo_slice;

  assign load    = (state_reg == IDLE) && bus.in_valid;
  assign a_slice = a_reg[step_reg*SLICE +: SLICE];
  assign b_slice = b_reg[step_reg*SLICE +: SLICE];

  // Single borrow chain shared by every step; the running borrow lives in borrow_reg.
  sub_slice #(.SLICE(SLICE)) u_slice (
    .d  (d_slice),
    .bo (bo_slice),
    .a  (a_slice),
    .b  (b_slice),
    .bi (borrow_reg)
  );

`ifdef SUB_OVERFLOW_EN
  logic ovf_reg, ovf_next;
`endif

  always_comb begin
    state_next  = state_reg;
    step_next   = step_reg;
    borrow_next = borrow_reg;
    d_next      = d_reg;
    bout_next   = bout_reg;
`ifdef SUB_OVERFLOW_EN
    ovf_next    = ovf_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          state_next  = RUN;
          step_next   = '0;
          borrow_next = bus.Bin;
          d_next      = '0;
          bout_next   = 1'b0;
`ifdef SUB_OVERFLOW_EN
          ovf_next    = 1'b0;
`endif
        end
      end
      RUN: begin
        d_next[step_reg*SLICE +: SLICE] = d_slice;
        borrow_next = bo_slice;
        step_next   = step_reg + 1'b1;
        if (step_reg == LAST_STEP) begin
          state_next = DONE;
          step_next  = '0;
          bout_next  = bo_slice;
`ifdef SUB_OVERFLOW_EN
          // The last slice carries the result sign bit.
          ovf_next   = (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) & (a_reg[WIDTH-1] ^ d_slice[SLICE-1]);
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      step_reg   <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      d_reg      <= '0;
      bout_reg   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf_reg    <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      step_reg   <= step_next;
      borrow_reg <= borrow_next;
      d_reg      <= d_next;
      bout_reg   <= bout_next;
`ifdef SUB_OVERFLOW_EN
      ovf_reg    <= ovf_next;
`endif
      if (load) begin
        a_reg <= bus.A;
        b_reg <= bus.B;
      end
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.D         = d_reg;
  assign bus.Bout      = bout_reg;
`ifdef SUB_OVERFLOW_EN
  assign bus.Ovf       = ovf_reg;
`endif
endmodule

// File: tb/tb_seq_ripple_subtractor.sv
// Directed + random scoreboard bench for seq_ripple_subtractor (WIDTH=16, SLICE=4).
module tb_seq_ripple_subtractor;
  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int STEPS = WIDTH / SLICE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_ripple_subtractor_if #(.WIDTH(WIDTH)) bus ();

  seq_ripple_subtractor #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin);
    exp_t           r;
    logic [WIDTH:0] diff;
    diff   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    r.d    = diff[WIDTH-1:0];
    r.bout = diff[WIDTH];
    r.ovf  = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ r.d[WIDTH-1]);
    return r;
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bin, input int hold, input string tag);
    exp_t             e;
    int               n;
    logic [WIDTH-1:0] d_seen;
    @(negedge clk);
    check({tag, ".in_ready_idle"}, bus.in_ready, 1);
    bus.A = a; bus.B = b; bus.Bin = bin; bus.in_valid = 1'b1;
    sb.push_back(model(a, b, bin));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A = ~a; bus.B = WIDTH'($urandom); bus.Bin = ~bin;
    check({tag, ".in_ready_run"}, bus.in_ready, 0);
    n = 1;
    while (!bus.out_valid && n < 4 * STEPS + 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, n, STEPS + 1);
    check({tag, ".out_valid"}, bus.out_valid, 1);
    e = sb.pop_front();
    check({tag, ".D"}, bus.D, e.d);
    check({tag, ".Bout"}, bus.Bout, e.bout);
`ifdef SUB_OVERFLOW_EN
    check({tag, ".Ovf"}, bus.Ovf, e.ovf);
`endif
    d_seen = bus.D;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = i[0];
      bus.A = WIDTH'($urandom);
      @(negedge clk);
      check({tag, ".hold_D"}, bus.D, d_seen);
      check({tag, ".hold_valid"}, bus.out_valid, 1);
      check({tag, ".hold_in_ready"}, bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, ".release_valid"}, bus.out_valid, 0);
    check({tag, ".release_in_ready"}, bus.in_ready, 1);
    $display("op %s: A=%h B=%h Bin=%b -> D=%h Bout=%b", tag, a, b, bin, d_seen, e.bout);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
    #1;
    check("reset.in_ready", bus.in_ready, 1);
    check("reset.out_valid", bus.out_valid, 0);
    check("reset.D", bus.D, 0);
    check("reset.Bout", bus.Bout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0234, 1'b0, 0, "basic");
    run_op(16'h0000, 16'h0001, 1'b0, 0, "underflow");
    run_op(16'h0005, 16'h0005, 1'b1, 0, "bin_wrap");
    run_op(16'hFFFF, 16'h0000, 1'b1, 0, "bin_nowrap");
    run_op(16'h0F0F, 16'h0101, 1'b0, 10, "backpressure");

    // Abort an operation after two slices have been resolved.
    @(negedge clk);
    bus.A = 16'hFFFF; bus.B = 16'h0000; bus.Bin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort.partial_D", bus.D, 16'h00FF);
    rst_n = 1'b0;
    #1;
    check("abort.out_valid", bus.out_valid, 0);
    check("abort.in_ready", bus.in_ready, 1);
    check("abort.D", bus.D, 0);
    check("abort.Bout", bus.Bout, 0);
`ifdef SUB_OVERFLOW_EN
    check("abort.Ovf", bus.Ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h00FF, 16'h000F, 1'b0, 0, "after_abort");

    run_op(16'h8000, 16'h0001, 1'b0, 0, "ovf_neg");
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, "ovf_pos");

    for (int i = 0; i < 20; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0, "random");
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
